// File: rtl/apb_uart.sv
// apb_uart
//   APB slave (selected by psel == 2'b10) wrapping a full-duplex UART.
//   The frame is 8 data bits, LSB first, and one stop bit. When the macro
//   UART_PARITY_EN is defined, an even-parity bit follows the data bits
//   (11-bit frame) and is checked on receive. Without it the parity bit is
//   skipped (10-bit frame) and STATUS bit 2 always reads 0.
//
//   Register map (full 32-bit pAdd decode):
//     0  TXDATA  write-only; the transfer stalls while the transmitter is busy
//     4  STATUS  read-only, zero wait states;
//                bit 0 = rx_valid, bit 1 = tx_busy, bit 2 = parity_err,
//                bit 3 = framing_err, bit 4 = overrun;
//                a completed read clears bits 2..4
//     15 RXDATA  read-only; the transfer stalls until a byte is available
//     other      completes at once, reads 0, writes are dropped
//
//   Ports:
//     clk            system clock, rising edge
//     rst_n          asynchronous active-low reset
//     psel[1:0]      slave select; this block answers only to 2'b10
//     pen            APB enable (access phase)
//     pwr            1 = write, 0 = read
//     pAdd[31:0]     byte address
//     pwData[31:0]   write data; only [7:0] is used
//     prdata[31:0]   read data; combinational, 0 unless pready is 1
//     pready         transfer-complete strobe; combinational
//     rxd            serial input, idles high
//     txd            serial output, idles high, registered
//
//   state    | meaning
//   S_IDLE   | line idle: TX waits for a write, RX waits for a falling edge
//   S_START  | start bit (RX counts to mid-bit and re-checks it)
//   S_DATA   | eight data bits, LSB first
//   S_PARITY | even-parity bit (UART_PARITY_EN only)
//   S_STOP   | stop bit
module apb_uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  psel,
    input  logic        pen,
    input  logic        pwr,
    input  logic [31:0] pAdd,
    input  logic [31:0] pwData,
    output logic [31:0] prdata,
    output logic        pready,
    input  logic        rxd,
    output logic        txd
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             txd_q;
`ifdef UART_PARITY_EN
    logic             tx_par_q;
    logic             rx_par_q;
`endif

    state_t           rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;
    logic             parity_err_q, framing_err_q, overrun_q;

    logic access, sel_tx, sel_st, sel_rx;
    logic tx_busy, tx_accept, rx_take, st_take;
    logic tx_tick, rx_tick, rx_fall;
    logic unused_pwdata;

    assign unused_pwdata = ^pwData[31:8];

    // ---------------- bus decode ----------------
    assign access = (psel == 2'b10) && pen;
    assign sel_tx = access &&  pwr && (pAdd == 32'd0);
    assign sel_st = access && !pwr && (pAdd == 32'd4);
    assign sel_rx = access && !pwr && (pAdd == 32'd15);

    assign tx_busy   = (tx_state_q != S_IDLE);
    assign tx_accept = sel_tx && !tx_busy;
    assign rx_take   = sel_rx && rx_valid_q;
    assign st_take   = sel_st;

    always_comb begin
        pready = 1'b0;
        prdata = 32'd0;
        if (access) begin
            if (sel_tx) begin
                pready = !tx_busy;
            end else if (sel_rx) begin
                pready = rx_valid_q;
                if (rx_valid_q) prdata = {24'd0, rx_byte_q};
            end else if (sel_st) begin
                pready = 1'b1;
                prdata = {27'd0, overrun_q, framing_err_q, parity_err_q, tx_busy, rx_valid_q};
            end else begin
                pready = 1'b1;
            end
        end
    end

    // ---------------- transmitter ----------------
    assign tx_tick = (tx_cnt_q == '0);
    assign txd     = txd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_accept) begin
                        tx_shift_q <= pwData[7:0];
`ifdef UART_PARITY_EN
                        tx_par_q   <= ^pwData[7:0];
`endif
                        tx_cnt_q   <= BIT_LAST;
                        txd_q      <= 1'b0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (!tx_tick) begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end else begin
                        tx_cnt_q   <= BIT_LAST;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= '0;
                        tx_state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!tx_tick) begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end else begin
                        tx_cnt_q <= BIT_LAST;
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd_q      <= tx_par_q;
                            tx_state_q <= S_PARITY;
`else
                            txd_q      <= 1'b1;
                            tx_state_q <= S_STOP;
`endif
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (!tx_tick) begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end else begin
                        tx_cnt_q   <= BIT_LAST;
                        txd_q      <= 1'b1;
                        tx_state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!tx_tick) tx_cnt_q <= tx_cnt_q - 1'b1;
                    else          tx_state_q <= S_IDLE;
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    assign rx_tick = (rx_cnt_q == '0);
    assign rx_fall = rx_s3_q && !rx_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_s3_q       <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q      <= 1'b0;
`endif
        end else begin
            // An unknown line level falls into the else branch and reads as idle-high.
            if (rxd == 1'b0) rx_s1_q <= 1'b0;
            else             rx_s1_q <= 1'b1;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;

            // Clears first; a byte or flag landing on the same edge overrides them.
            if (rx_take) rx_valid_q <= 1'b0;
            if (st_take) begin
                parity_err_q  <= 1'b0;
                framing_err_q <= 1'b0;
                overrun_q     <= 1'b0;
            end

            case (rx_state_q)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt_q   <= HALF_LAST;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else if (rx_s2_q) begin
                        rx_state_q <= S_IDLE;
                    end else begin
                        rx_cnt_q   <= BIT_LAST;
                        rx_bit_q   <= '0;
                        rx_state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else begin
                        rx_cnt_q   <= BIT_LAST;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= S_PARITY;
`else
                            rx_state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else begin
                        rx_cnt_q   <= BIT_LAST;
                        rx_par_q   <= rx_s2_q;
                        rx_state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else begin
                        rx_byte_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        // A byte read out on this very edge is not lost, so no overrun.
                        if (rx_valid_q && !rx_take) overrun_q <= 1'b1;
                        if (!rx_s2_q) framing_err_q <= 1'b1;
`ifdef UART_PARITY_EN
                        if ((^rx_shift_q) != rx_par_q) parity_err_q <= 1'b1;
`endif
                        rx_state_q <= S_IDLE;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart.sv
`timescale 1ns/100ps
module tb_apb_uart;
    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam int          RX_LAT     = 170;
    localparam int          TX_HOLD    = 176;
    localparam logic [10:0] TX55_SEQ   = 11'b10010101010;
    localparam logic [31:0] ST_PAR1    = 32'h05;
`else
    localparam int          FRAME_BITS = 10;
    localparam int          RX_LAT     = 154;
    localparam int          TX_HOLD    = 160;
    localparam logic [10:0] TX55_SEQ   = 11'b01010101010;
    localparam logic [31:0] ST_PAR1    = 32'h01;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  psel;
    logic        pen, pwr;
    logic [31:0] pAdd, pwData, prdata;
    logic        pready, rxd, txd;

    int vectors = 0;
    int miscompares = 0;

    apb_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .pen(pen), .pwr(pwr),
        .pAdd(pAdd), .pwData(pwData), .prdata(prdata), .pready(pready),
        .rxd(rxd), .txd(txd)
    );

    always #1 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int         at;
        logic [7:0] b;
        logic       pe;
        logic       fe;
    } rx_ev_t;

    rx_ev_t      evq[$];
    int          cyc = 0;
    int          m_tx_left = 0;
    logic [10:0] m_tx_bits = '0;
    logic        m_rx_valid = 1'b0;
    logic [7:0]  m_rx_byte = '0;
    logic        m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tx_left  = 0;
            m_rx_valid = 1'b0;
            m_rx_byte  = '0;
            m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            evq.delete();
        end else begin
            logic acc, take_rx, take_st, go_tx, was_valid;
            acc     = (psel == 2'b10) && pen;
            take_rx = acc && !pwr && (pAdd == 32'd15) && m_rx_valid;
            take_st = acc && !pwr && (pAdd == 32'd4);
            go_tx   = acc &&  pwr && (pAdd == 32'd0) && (m_tx_left == 0);
            was_valid = m_rx_valid;
            cyc++;
            if (m_tx_left > 0) m_tx_left--;
            if (go_tx) begin
                m_tx_left = FRAME_CYC;
                m_tx_bits = '0;
                for (int i = 0; i < 8; i++) m_tx_bits[i+1] = pwData[i];
`ifdef UART_PARITY_EN
                m_tx_bits[9]  = ^pwData[7:0];
                m_tx_bits[10] = 1'b1;
`else
                m_tx_bits[9]  = 1'b1;
`endif
            end
            if (take_rx) m_rx_valid = 1'b0;
            if (take_st) begin m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0; end
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (was_valid && !take_rx) m_ov = 1'b1;
                m_rx_valid = 1'b1;
                m_rx_byte  = evq[0].b;
                if (evq[0].pe) m_pe = 1'b1;
                if (evq[0].fe) m_fe = 1'b1;
                void'(evq.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          rx_pulses = 0;
    int          rx_bad = 0;
    logic [31:0] last_rx = '0;

    initial begin
        forever begin
            logic        e_rdy, e_txd;
            logic [31:0] e_rd;
            @(negedge clk);
            #0.5;
            e_rdy = 1'b0;
            e_rd  = 32'd0;
            if (psel == 2'b10 && pen) begin
                if (pwr && pAdd == 32'd0) begin
                    e_rdy = (m_tx_left == 0);
                end else if (!pwr && pAdd == 32'd15) begin
                    e_rdy = m_rx_valid;
                    if (m_rx_valid) e_rd = {24'd0, m_rx_byte};
                end else if (!pwr && pAdd == 32'd4) begin
                    e_rdy = 1'b1;
                    e_rd  = {27'd0, m_ov, m_fe, m_pe, (m_tx_left != 0), m_rx_valid};
                end else begin
                    e_rdy = 1'b1;
                end
            end
            e_txd = (m_tx_left == 0) ? 1'b1 : m_tx_bits[(FRAME_CYC - m_tx_left) / CPB];
            vectors++;
            if (pready !== e_rdy || prdata !== e_rd || txd !== e_txd) begin
                miscompares++;
                $display("FAIL cycle %0d: pready=%b prdata=%h txd=%b, required pready=%b prdata=%h txd=%b",
                         cyc, pready, prdata, txd, e_rdy, e_rd, e_txd);
            end
            if (pready && psel == 2'b10 && pen && !pwr && pAdd == 32'd15) begin
                rx_pulses++;
                last_rx = prdata;
                if (prdata != 32'h000000AA) rx_bad++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apb_set(input logic [1:0] s, input logic e, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        psel = s; pen = e; pwr = w; pAdd = a; pwData = d;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_once(input logic [31:0] a, input string name, input logic [31:0] exp);
        @(negedge clk);
        apb_set(2'b10, 1'b1, 1'b0, a, 32'd0);
        #0.5;
        chk({name, "_rdy"}, 32'(pready), 32'd1);
        chk(name, prdata, exp);
        @(negedge clk);
        apb_set(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        rx_ev_t ev;
        @(negedge clk);
        rxd   = 1'b0;
        ev.at = cyc + 1 + RX_LAT;
        ev.b  = b;
`ifdef UART_PARITY_EN
        ev.pe = (par != ^b);
`else
        ev.pe = par & 1'b0;
`endif
        ev.fe = ~stp;
        evq.push_back(ev);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rxd = par;
        repeat (CPB) @(negedge clk);
`endif
        rxd = stp;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          hold;
        logic        done;
        logic [10:0] seq;
        int          gaps [4] = '{1, 3, 5, 2};

        rst_n = 1'b0;
        rxd   = 1'b1;
        apb_set(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3);
        #0.5;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // GPIO select must be ignored; unmapped read and STATUS write complete at once
        apb_set(2'b01, 1'b1, 1'b0, 32'd15, 32'd0);
        idle(3);
        apb_set(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        read_once(32'd8, "rd_unmapped", 32'd0);
        @(negedge clk);
        apb_set(2'b10, 1'b1, 1'b1, 32'd4, 32'hFF);
        #0.5;
        chk("wr_status_rdy", 32'(pready), 32'd1);
        @(negedge clk);
        apb_set(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        read_once(32'd4, "status_idle", 32'd0);

        // single frame with continuous RXDATA read
        @(negedge clk);
        apb_set(2'b10, 1'b1, 1'b0, 32'd15, 32'd0);
        rx_pulses = 0;
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(20);
        chk("rx1_pulses", rx_pulses, 32'd1);
        chk("rx1_data", last_rx, 32'h000000AA);
        apb_set(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        read_once(32'd4, "rx1_status", 32'd0);

        // glitch shorter than half a bit is not a start
        @(negedge clk);
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(2 * CPB);
        read_once(32'd4, "false_start_status", 32'd0);

        // four frames with short idle gaps
        @(negedge clk);
        apb_set(2'b10, 1'b1, 1'b0, 32'd15, 32'd0);
        rx_pulses = 0;
        rx_bad = 0;
        for (int f = 0; f < 4; f++) begin
            send_frame(8'hAA, 1'b0, 1'b1);
            idle(gaps[f]);
        end
        idle(20);
        chk("rx4_pulses", rx_pulses, 32'd4);
        chk("rx4_bad_data", rx_bad, 32'd0);
        apb_set(2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        read_once(32'd4, "rx4_status", 32'd0);

        // wrong parity bit
        send_frame(8'hAA, 1'b1, 1'b1);
        idle(20);
        read_once(32'd4, "par_status", ST_PAR1);
        read_once(32'd15, "par_data", 32'h000000AA);
        read_once(32'd4, "par_status_after", 32'd0);

        // stop bit low
        send_frame(8'h0F, 1'b0, 1'b0);
        idle(20);
        read_once(32'd4, "frm_status", 32'h09);
        read_once(32'd15, "frm_data", 32'h0000000F);

        // overrun: second byte replaces the first
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(3);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(20);
        read_once(32'd4, "ovr_status", 32'h11);
        read_once(32'd15, "ovr_data", 32'h000000C3);
        read_once(32'd4, "ovr_status_after", 32'd0);

        // transmit 0x55, then hold a second write until the frame ends
        @(negedge clk);
        apb_set(2'b10, 1'b1, 1'b1, 32'd0, 32'h55);
        #0.5;
        chk("tx_first_rdy", 32'(pready), 32'd1);
        hold = 0;
        done = 1'b0;
        seq  = '0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (i == 0) pwData = 32'h33;
            #0.5;
            if (i % CPB == CPB / 2 && i / CPB < FRAME_BITS) seq[i / CPB] = txd;
            if (pready) done = 1'b1;
            else        hold++;
        end
        chk("tx_second_done", 32'(done), 32'd1);
        chk("tx_hold_cycles", hold, TX_HOLD);
        chk("tx_bits_0x55", 32'(seq), 32'(TX55_SEQ));
        read_once(32'd4, "status_tx_busy", 32'h02);

        // reset in the middle of the second frame
        idle(60);
        rst_n = 1'b0;
        #0.5;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        idle(2);
        rst_n = 1'b1;
        idle(5);
        read_once(32'd4, "status_after_rst", 32'd0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
